// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite types, response codes and slave FSM states
package axi_lite_pkg;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 8;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int BUFFER_SIZE = 4096;
  typedef logic [AXI_ADDR_W-1:0] addr_t;
  typedef logic [AXI_DATA_W-1:0] data_t;
  typedef logic [AXI_STRB_W-1:0] strb_t;
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/axi_lite_mem_array.sv
// axi_lite_mem_array: byte memory with registered read, read-before-write on collision
module axi_lite_mem_array #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end
endmodule

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite responder with independent write/read FSMs over a local byte memory
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_W,
  parameter int DATA_WIDTH = AXI_DATA_W,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = BUFFER_SIZE
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output resp_t                 BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output resp_t                 RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_DEPTH);
  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic live, aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, wr_hit, rd_hit, wr_en, ws_q, strb_eff, rd_ok;
  logic [ADDR_WIDTH-1:0] aw_q, wr_addr;
  logic [DATA_WIDTH-1:0] wd_q, wr_data, rd_q;
  // live holds READYs low until the first edge after reset release
  always_comb begin
    AWREADY = live && (wr_state == W_IDLE || wr_state == W_GOT_DATA);
    WREADY = live && (wr_state == W_IDLE || wr_state == W_GOT_ADDR);
    BVALID = wr_state == W_RESP;
    ARREADY = live && rd_state == R_IDLE;
    RVALID = rd_state == R_DATA;
    RDATA = rd_ok ? rd_q : '0;
    aw_hs = AWVALID && AWREADY;
    w_hs = WVALID && WREADY;
    b_hs = BVALID && BREADY;
    ar_hs = ARVALID && ARREADY;
    r_hs = RVALID && RREADY;
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE:     wr_next = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_GOT_ADDR : w_hs ? W_GOT_DATA : W_IDLE;
      W_GOT_ADDR: wr_next = w_hs ? W_RESP : W_GOT_ADDR;
      W_GOT_DATA: wr_next = aw_hs ? W_RESP : W_GOT_DATA;
      default:    wr_next = b_hs ? W_IDLE : W_RESP;
    endcase
    rd_next = rd_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (r_hs ? R_IDLE : R_DATA);
    wr_addr = aw_hs ? AWADDR : aw_q;
    wr_data = w_hs ? WDATA : wd_q;
    strb_eff = w_hs ? WSTRB[0] : ws_q;
    wr_hit = wr_addr < LIMIT;
    rd_hit = ARADDR < LIMIT;
    commit = wr_next == W_RESP && wr_state != W_RESP;
    wr_en = commit && wr_hit && strb_eff;
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      live <= 1'b0;
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
      BRESP <= RESP_OKAY;
      RRESP <= RESP_OKAY;
      rd_ok <= 1'b0;
      aw_q <= '0;
      wd_q <= '0;
      ws_q <= 1'b0;
    end else begin
      live <= 1'b1;
      wr_state <= wr_next;
      rd_state <= rd_next;
      if (aw_hs) aw_q <= AWADDR;
      if (w_hs) begin
        wd_q <= WDATA;
        ws_q <= WSTRB[0];
      end
      if (commit) BRESP <= wr_hit ? RESP_OKAY : RESP_DECERR;
      if (ar_hs) begin
        RRESP <= rd_hit ? RESP_OKAY : RESP_DECERR;
        rd_ok <= rd_hit;
      end
    end
  end
  axi_lite_mem_array #(.DEPTH(MEM_DEPTH), .WIDTH(DATA_WIDTH)) u_mem (
    .clk(ACLK),
    .wr_en(wr_en),
    .wr_idx(wr_addr[IDX_W-1:0]),
    .wr_data(wr_data),
    .rd_en(ar_hs),
    .rd_idx(ARADDR[IDX_W-1:0]),
    .rd_data(rd_q)
  );
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave: scoreboard bench with a byte-map reference model and randomized traffic
module tb_axi_lite_mem_slave;
  logic ACLK = 1'b0, ARESETn = 1'b0;
  logic [31:0] AWADDR = '0, ARADDR = '0;
  logic AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b1, ARVALID = 1'b0, RREADY = 1'b1;
  logic [7:0] WDATA = '0, RDATA;
  logic [0:0] WSTRB = 1'b0;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0] BRESP, RRESP;
  int checks = 0, errors = 0;
  logic [1:0] bq[$];
  logic [9:0] rq[$];
  logic [7:0] mem [logic [31:0]];
  logic pb_v = 1'b0, pb_hs = 1'b0, pr_v = 1'b0, pr_hs = 1'b0;
  logic [1:0] pb_resp = '0;
  logic [9:0] pr_val = '0;

  axi_lite_mem_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return a < 32'd4096 ? 2'b00 : 2'b11;
  endfunction

  // Monitor: pops the scoreboard on every response handshake, checks stalls are stable
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (BVALID) begin
        chk("b_readys_low", 32'({AWREADY, WREADY}), 32'd0);
        if (pb_v && !pb_hs) chk("b_stable", 32'(BRESP), 32'(pb_resp));
      end
      if (BVALID && BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
        else chk("bresp", 32'(BRESP), 32'(bq.pop_front()));
      end
      if (RVALID) begin
        chk("r_arready_low", 32'(ARREADY), 32'd0);
        if (pr_v && !pr_hs) chk("r_stable", 32'({RRESP, RDATA}), 32'(pr_val));
      end
      if (RVALID && RREADY) begin
        if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
        else chk("rresp_rdata", 32'({RRESP, RDATA}), 32'(rq.pop_front()));
      end
      pb_v = BVALID; pb_hs = BVALID && BREADY; pb_resp = BRESP;
      pr_v = RVALID; pr_hs = RVALID && RREADY; pr_val = {RRESP, RDATA};
    end else begin
      pb_v = 1'b0; pr_v = 1'b0;
    end
  end

  task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic s,
                    input int da, input int dw, input int bstall);
    int n;
    bq.push_back(exp_resp(a));
    BREADY = (bstall == 0);
    fork
      begin
        int k = 0;
        repeat (da) @(posedge ACLK);
        #1;
        if (da > dw) chk("wready_low_waiting_aw", 32'(WREADY), 32'd0);
        AWADDR = a; AWVALID = 1'b1;
        @(negedge ACLK);
        while (!AWREADY && k < 50) begin @(negedge ACLK); k++; end
        if (!AWREADY) chk("aw_timeout", 32'(AWREADY), 32'd1);
        @(posedge ACLK); #1 AWVALID = 1'b0;
      end
      begin
        int k = 0;
        repeat (dw) @(posedge ACLK);
        #1;
        if (dw > da) chk("awready_low_waiting_w", 32'(AWREADY), 32'd0);
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        @(negedge ACLK);
        while (!WREADY && k < 50) begin @(negedge ACLK); k++; end
        if (!WREADY) chk("w_timeout", 32'(WREADY), 32'd1);
        @(posedge ACLK); #1 WVALID = 1'b0;
      end
    join
    chk("b_latency", 32'(BVALID), 32'd1);
    if (s && a < 32'd4096) mem[a] = d;
    if (bstall > 0) begin
      repeat (bstall) @(posedge ACLK);
      #1 BREADY = 1'b1;
    end
    n = 0;
    @(negedge ACLK);
    while (!(BVALID && BREADY) && n < 50) begin @(negedge ACLK); n++; end
    if (!BVALID) chk("b_timeout", 32'(BVALID), 32'd1);
    @(posedge ACLK); #1;
  endtask

  task automatic rd(input logic [31:0] a, input int rstall);
    int n = 0;
    RREADY = (rstall == 0);
    ARADDR = a; ARVALID = 1'b1;
    @(negedge ACLK);
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!ARREADY) chk("ar_timeout", 32'(ARREADY), 32'd1);
    rq.push_back({exp_resp(a), a < 32'd4096 ? mem[a] : 8'h00});
    @(posedge ACLK); #1 ARVALID = 1'b0;
    chk("r_latency", 32'(RVALID), 32'd1);
    if (rstall > 0) begin
      repeat (rstall) @(posedge ACLK);
      #1 RREADY = 1'b1;
    end
    n = 0;
    @(negedge ACLK);
    while (!(RVALID && RREADY) && n < 50) begin @(negedge ACLK); n++; end
    if (!RVALID) chk("r_timeout", 32'(RVALID), 32'd1);
    @(posedge ACLK); #1;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] oor [4] = '{32'h1000, 32'h2000, 32'hFFFF_FFFF, 32'h0001_0004};
    return ($urandom_range(7) == 0) ? oor[$urandom_range(3)] : 32'($urandom_range(31));
  endfunction

  initial begin
    repeat (3) @(negedge ACLK);
    chk("rst_readys", 32'({AWREADY, WREADY, ARREADY}), 32'd0);
    chk("rst_valids", 32'({BVALID, RVALID}), 32'd0);
    chk("rst_resps", 32'({BRESP, RRESP}), 32'd0);
    chk("rst_rdata", 32'(RDATA), 32'd0);
    @(posedge ACLK); #1 ARESETn = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    chk("readys_after_rst", 32'({AWREADY, WREADY, ARREADY}), 32'h7);
    @(posedge ACLK); #1;
    wr(32'h0, 8'h5A, 1'b1, 0, 0, 0);
    wr(32'h4, 8'hA5, 1'b1, 0, 0, 0);
    rd(32'h4, 0);
    wr(32'h14, 8'h3C, 1'b1, 3, 0, 0);
    rd(32'h14, 0);
    wr(32'h1000, 8'h99, 1'b1, 0, 0, 0);
    rd(32'h2000, 0);
    rd(32'h0, 0);
    wr(32'h8, 8'hE7, 1'b1, 0, 2, 0);
    wr(32'h8, 8'h00, 1'b0, 1, 1, 0);
    rd(32'h8, 0);
    wr(32'hC, 8'h6D, 1'b1, 0, 0, 5);
    rd(32'hC, 5);
    wr(32'h4, 8'h11, 1'b1, 0, 0, 0);
    fork
      wr(32'h4, 8'h22, 1'b1, 0, 0, 0);
      rd(32'h4, 0);
    join
    rd(32'h4, 0);
    for (int i = 0; i < 32; i++)
      wr(32'(i), 8'($urandom), 1'b1, $urandom_range(3), $urandom_range(3), 0);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1) == 0)
        wr(pick_addr(), 8'($urandom), 1'($urandom_range(1)), $urandom_range(3), $urandom_range(3), $urandom_range(2));
      else
        rd(pick_addr(), $urandom_range(2));
    end
    AWADDR = 32'h10; WDATA = 8'h77; WSTRB = 1'b1; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    @(posedge ACLK); #1 AWVALID = 1'b0; WVALID = 1'b0;
    mem[32'h10] = 8'h77;
    @(negedge ACLK);
    chk("pending_b_before_rst", 32'(BVALID), 32'd1);
    #1 ARESETn = 1'b0;
    #1;
    chk("bvalid_async_drop", 32'(BVALID), 32'd0);
    chk("readys_in_rst", 32'({AWREADY, WREADY, ARREADY}), 32'd0);
    @(posedge ACLK); #1 ARESETn = 1'b1; BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    chk("readys_after_rerst", 32'({AWREADY, WREADY, ARREADY}), 32'h7);
    @(posedge ACLK); #1;
    wr(32'h18, 8'hC3, 1'b1, 0, 0, 0);
    rd(32'h18, 0);
    rd(32'h10, 0);
    repeat (4) @(posedge ACLK);
    @(negedge ACLK);
    chk("bq_drained", 32'(bq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
